// File: rtl/tl_ul_rr_arbiter.sv
// Two-requester TL-UL arbiter: round-robin A grant with stall lock, source-tagged
// D routing, per-requester outstanding cap and a sticky unexpected-D flag.
module tl_ul_rr_arbiter #(
  parameter int SRC_W   = 2,
  parameter int MAX_OUT = 4
) (
  input  logic               clock,
  input  logic               reset,

  input  logic               in0_a_valid,
  output logic               in0_a_ready,
  input  logic [2:0]         in0_a_opcode,
  input  logic [2:0]         in0_a_param,
  input  logic [3:0]         in0_a_size,
  input  logic [SRC_W-1:0]   in0_a_source,
  input  logic [31:0]        in0_a_address,
  input  logic [3:0]         in0_a_mask,
  input  logic [31:0]        in0_a_data,
  output logic               in0_d_valid,
  input  logic               in0_d_ready,
  output logic [2:0]         in0_d_opcode,
  output logic [3:0]         in0_d_size,
  output logic [SRC_W-1:0]   in0_d_source,
  output logic               in0_d_denied,
  output logic [31:0]        in0_d_data,

  input  logic               in1_a_valid,
  output logic               in1_a_ready,
  input  logic [2:0]         in1_a_opcode,
  input  logic [2:0]         in1_a_param,
  input  logic [3:0]         in1_a_size,
  input  logic [SRC_W-1:0]   in1_a_source,
  input  logic [31:0]        in1_a_address,
  input  logic [3:0]         in1_a_mask,
  input  logic [31:0]        in1_a_data,
  output logic               in1_d_valid,
  input  logic               in1_d_ready,
  output logic [2:0]         in1_d_opcode,
  output logic [3:0]         in1_d_size,
  output logic [SRC_W-1:0]   in1_d_source,
  output logic               in1_d_denied,
  output logic [31:0]        in1_d_data,

  output logic               out_a_valid,
  input  logic               out_a_ready,
  output logic [2:0]         out_a_opcode,
  output logic [2:0]         out_a_param,
  output logic [3:0]         out_a_size,
  output logic [SRC_W:0]     out_a_source,
  output logic [31:0]        out_a_address,
  output logic [3:0]         out_a_mask,
  output logic [31:0]        out_a_data,
  input  logic               out_d_valid,
  output logic               out_d_ready,
  input  logic [2:0]         out_d_opcode,
  input  logic [3:0]         out_d_size,
  input  logic [SRC_W:0]     out_d_source,
  input  logic               out_d_denied,
  input  logic [31:0]        out_d_data,

  output logic               err_unexpected_d
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  logic          prio, lock_valid, lock_idx, err;
  logic [CW-1:0] cnt0, cnt1, cnt0_nxt, cnt1_nxt;
  logic          elig0, elig1, grant, elig_grant;
  logic          a_fire, d_tag, d_fire, d_unexpected;

  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c,
                                             input logic a, input logic d);
    logic [CW-1:0] r;
    r = c;
    if (a && !d)
      r = c + CW'(1);
    else if (d && !a && c != '0)
      r = c - CW'(1);
    return r;
  endfunction

  // Eligibility uses the registered counts, so a same-cycle D never unblocks a capped requester.
  always_comb begin
    elig0 = in0_a_valid & (cnt0 < MAX_CNT);
    elig1 = in1_a_valid & (cnt1 < MAX_CNT);
    if (lock_valid)
      grant = lock_idx;
    else if (elig0 & elig1)
      grant = prio;
    else
      grant = elig1;
    elig_grant = grant ? elig1 : elig0;
  end

  assign out_a_valid   = elig_grant & ~reset;
  assign in0_a_ready   = out_a_ready & ~grant & elig0 & ~reset;
  assign in1_a_ready   = out_a_ready &  grant & elig1 & ~reset;
  assign out_a_opcode  = grant ? in1_a_opcode  : in0_a_opcode;
  assign out_a_param   = grant ? in1_a_param   : in0_a_param;
  assign out_a_size    = grant ? in1_a_size    : in0_a_size;
  assign out_a_source  = {grant, (grant ? in1_a_source : in0_a_source)};
  assign out_a_address = grant ? in1_a_address : in0_a_address;
  assign out_a_mask    = grant ? in1_a_mask    : in0_a_mask;
  assign out_a_data    = grant ? in1_a_data    : in0_a_data;
  assign a_fire        = out_a_valid & out_a_ready;

  assign d_tag        = out_d_source[SRC_W];
  assign in0_d_valid  = out_d_valid & ~d_tag & ~reset;
  assign in1_d_valid  = out_d_valid &  d_tag & ~reset;
  assign out_d_ready  = (d_tag ? in1_d_ready : in0_d_ready) & ~reset;
  assign d_fire       = out_d_valid & out_d_ready;
  assign d_unexpected = d_fire & ((d_tag ? cnt1 : cnt0) == '0);

  assign in0_d_opcode = out_d_opcode;
  assign in0_d_size   = out_d_size;
  assign in0_d_source = out_d_source[SRC_W-1:0];
  assign in0_d_denied = out_d_denied;
  assign in0_d_data   = out_d_data;
  assign in1_d_opcode = out_d_opcode;
  assign in1_d_size   = out_d_size;
  assign in1_d_source = out_d_source[SRC_W-1:0];
  assign in1_d_denied = out_d_denied;
  assign in1_d_data   = out_d_data;

  always_comb begin
    cnt0_nxt = cnt_next(cnt0, a_fire & ~grant, d_fire & ~d_tag);
    cnt1_nxt = cnt_next(cnt1, a_fire &  grant, d_fire &  d_tag);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio       <= 1'b0;
      lock_valid <= 1'b0;
      lock_idx   <= 1'b0;
      cnt0       <= '0;
      cnt1       <= '0;
      err        <= 1'b0;
    end else begin
      // Hold the grant across a stall so the presented beat stays stable.
      lock_valid <= out_a_valid & ~out_a_ready;
      lock_idx   <= grant;
      if (a_fire)
        prio <= ~grant;
      cnt0 <= cnt0_nxt;
      cnt1 <= cnt1_nxt;
      if (d_unexpected)
        err <= 1'b1;
    end
  end

  assign err_unexpected_d = err;

endmodule

// File: tb/tb_tl_ul_rr_arbiter.sv
// Bench for tl_ul_rr_arbiter: expected out-A beats are queued as stimulus is
// driven and compared when they fire; D routing and counters are checked directly.
module tb_tl_ul_rr_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        in0_a_valid, in0_a_ready, in1_a_valid, in1_a_ready;
  logic [2:0]  in0_a_opcode, in0_a_param, in1_a_opcode, in1_a_param;
  logic [3:0]  in0_a_size, in1_a_size, in0_a_mask, in1_a_mask;
  logic [1:0]  in0_a_source, in1_a_source;
  logic [31:0] in0_a_address, in1_a_address, in0_a_data, in1_a_data;
  logic        in0_d_valid, in0_d_ready, in1_d_valid, in1_d_ready;
  logic [2:0]  in0_d_opcode, in1_d_opcode;
  logic [3:0]  in0_d_size, in1_d_size;
  logic [1:0]  in0_d_source, in1_d_source;
  logic        in0_d_denied, in1_d_denied;
  logic [31:0] in0_d_data, in1_d_data;
  logic        out_a_valid, out_a_ready;
  logic [2:0]  out_a_opcode, out_a_param;
  logic [3:0]  out_a_size, out_a_mask;
  logic [2:0]  out_a_source;
  logic [31:0] out_a_address, out_a_data;
  logic        out_d_valid, out_d_ready;
  logic [2:0]  out_d_opcode;
  logic [3:0]  out_d_size;
  logic [2:0]  out_d_source;
  logic        out_d_denied;
  logic [31:0] out_d_data;
  logic        err_unexpected_d;

  tl_ul_rr_arbiter #(.SRC_W(2), .MAX_OUT(4)) dut (
    .clock(clock), .reset(reset),
    .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready), .in0_a_opcode(in0_a_opcode),
    .in0_a_param(in0_a_param), .in0_a_size(in0_a_size), .in0_a_source(in0_a_source),
    .in0_a_address(in0_a_address), .in0_a_mask(in0_a_mask), .in0_a_data(in0_a_data),
    .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready), .in0_d_opcode(in0_d_opcode),
    .in0_d_size(in0_d_size), .in0_d_source(in0_d_source), .in0_d_denied(in0_d_denied),
    .in0_d_data(in0_d_data),
    .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready), .in1_a_opcode(in1_a_opcode),
    .in1_a_param(in1_a_param), .in1_a_size(in1_a_size), .in1_a_source(in1_a_source),
    .in1_a_address(in1_a_address), .in1_a_mask(in1_a_mask), .in1_a_data(in1_a_data),
    .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready), .in1_d_opcode(in1_d_opcode),
    .in1_d_size(in1_d_size), .in1_d_source(in1_d_source), .in1_d_denied(in1_d_denied),
    .in1_d_data(in1_d_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_size(out_d_size), .out_d_source(out_d_source), .out_d_denied(out_d_denied),
    .out_d_data(out_d_data),
    .err_unexpected_d(err_unexpected_d)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]  src;
    logic [2:0]  opcode;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input int n, input logic v, input logic [1:0] src,
                         input logic [2:0] opc, input logic [31:0] addr, input logic [31:0] data);
    if (n == 0) begin
      in0_a_valid = v; in0_a_source = src; in0_a_opcode = opc;
      in0_a_address = addr; in0_a_data = data;
    end else begin
      in1_a_valid = v; in1_a_source = src; in1_a_opcode = opc;
      in1_a_address = addr; in1_a_data = data;
    end
  endtask

  task automatic expect_beat(input int n, input logic [1:0] src, input logic [2:0] opc,
                             input logic [31:0] addr, input logic [31:0] data);
    beat_t b;
    b.src = {n[0], src}; b.opcode = opc; b.addr = addr; b.data = data;
    sb.push_back(b);
  endtask

  task automatic send_d(input logic [2:0] src);
    out_d_valid = 1'b1; out_d_source = src;
    in0_d_ready = 1'b1; in1_d_ready = 1'b1;
    cyc();
    out_d_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset && out_a_valid && out_a_ready) begin
      if (sb.size() == 0) begin
        check("a_unexpected_beat", 1, 0);
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("a_source", out_a_source, e.src);
        check("a_opcode", out_a_opcode, e.opcode);
        check("a_address", out_a_address, e.addr);
        check("a_data", out_a_data, e.data);
      end
    end
  end

  initial begin
    in0_a_param = 3'd0; in1_a_param = 3'd0; in0_a_size = 4'd2; in1_a_size = 4'd2;
    in0_a_mask = 4'hf; in1_a_mask = 4'hf;
    drive_a(0, 1'b1, 2'b00, 3'd4, 32'h0, 32'h0);
    drive_a(1, 1'b0, 2'b00, 3'd4, 32'h0, 32'h0);
    in0_d_ready = 1'b1; in1_d_ready = 1'b1; out_a_ready = 1'b1;
    out_d_valid = 1'b1; out_d_source = 3'b100; out_d_opcode = 3'd1;
    out_d_size = 4'd2; out_d_denied = 1'b0; out_d_data = 32'h0;
    reset = 1'b1;

    // reset gating
    @(negedge clock);
    check("rst_in0_a_ready", in0_a_ready, 0);
    check("rst_out_a_valid", out_a_valid, 0);
    check("rst_out_d_ready", out_d_ready, 0);
    check("rst_in1_d_valid", in1_d_valid, 0);
    cyc(); cyc();
    reset = 1'b0;
    in0_a_valid = 1'b0; out_d_valid = 1'b0;
    @(negedge clock);
    check("rst_err", err_unexpected_d, 0);
    check("rst_out_a_valid_idle", out_a_valid, 0);
    check("rst_cnt0", dut.cnt0, 0);
    cyc();

    // alternating grants
    drive_a(0, 1'b1, 2'b01, 3'd4, 32'h0000_00a0, 32'h0000_d000);
    drive_a(1, 1'b1, 2'b10, 3'd0, 32'h0000_00b0, 32'h0000_e000);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) expect_beat(0, 2'b01, 3'd4, 32'h0000_00a0, 32'h0000_d000);
      else            expect_beat(1, 2'b10, 3'd0, 32'h0000_00b0, 32'h0000_e000);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("rr_readies", {in1_a_ready, in0_a_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      cyc();
    end
    in0_a_valid = 1'b0; in1_a_valid = 1'b0;
    @(negedge clock);
    check("rr_cnt0", dut.cnt0, 2);
    check("rr_cnt1", dut.cnt1, 2);
    cyc();
    send_d(3'b000); send_d(3'b001); send_d(3'b110); send_d(3'b111);
    @(negedge clock);
    check("drain_cnt0", dut.cnt0, 0);
    check("drain_cnt1", dut.cnt1, 0);
    cyc();

    // stalled grant must hold even when prio points at the other requester
    drive_a(0, 1'b1, 2'b11, 3'd4, 32'h0000_00c0, 32'h0000_0011);
    expect_beat(0, 2'b11, 3'd4, 32'h0000_00c0, 32'h0000_0011);
    @(negedge clock);
    cyc();
    drive_a(0, 1'b1, 2'b11, 3'd4, 32'h0000_00c4, 32'h0000_0022);
    out_a_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("lock_valid_out", out_a_valid, 1);
      check("lock_src", out_a_source, 3'b011);
      cyc();
    end
    drive_a(1, 1'b1, 2'b00, 3'd0, 32'h0000_00b8, 32'h0000_0033);
    @(negedge clock);
    check("lock_hold_src", out_a_source, 3'b011);
    check("lock_hold_addr", out_a_address, 32'h0000_00c4);
    check("lock_in1_ready", in1_a_ready, 0);
    cyc();
    out_a_ready = 1'b1;
    expect_beat(0, 2'b11, 3'd4, 32'h0000_00c4, 32'h0000_0022);
    expect_beat(1, 2'b00, 3'd0, 32'h0000_00b8, 32'h0000_0033);
    @(negedge clock);
    check("lock_release_in0", in0_a_ready, 1);
    cyc();
    in0_a_valid = 1'b0;
    @(negedge clock);
    check("lock_next_in1", in1_a_ready, 1);
    cyc();
    in1_a_valid = 1'b0;
    send_d(3'b011); send_d(3'b011); send_d(3'b100);

    // outstanding cap
    for (int i = 0; i < 4; i++) begin
      drive_a(0, 1'b1, 2'b10, 3'd4, 32'h100 + 32'(4 * i), 32'h0);
      expect_beat(0, 2'b10, 3'd4, 32'h100 + 32'(4 * i), 32'h0);
      @(negedge clock);
      check("cap_fill_ready", in0_a_ready, 1);
      cyc();
    end
    drive_a(0, 1'b1, 2'b10, 3'd4, 32'h0000_0110, 32'h0000_0055);
    drive_a(1, 1'b1, 2'b01, 3'd0, 32'h0000_00b0, 32'h0000_e000);
    expect_beat(1, 2'b01, 3'd0, 32'h0000_00b0, 32'h0000_e000);
    @(negedge clock);
    check("cap_in0_blocked", in0_a_ready, 0);
    check("cap_in1_through", in1_a_ready, 1);
    cyc();
    in1_a_valid = 1'b0;
    @(negedge clock);
    check("cap_no_valid", out_a_valid, 0);
    cyc();
    out_d_valid = 1'b1; out_d_source = 3'b010; in0_d_ready = 1'b1;
    @(negedge clock);
    check("cap_d_same_cycle", out_a_valid, 0);
    check("cap_d_route", in0_d_valid, 1);
    cyc();
    out_d_valid = 1'b0;
    expect_beat(0, 2'b10, 3'd4, 32'h0000_0110, 32'h0000_0055);
    @(negedge clock);
    check("cap_reenabled", in0_a_ready, 1);
    cyc();
    in0_a_valid = 1'b0;
    send_d(3'b000); send_d(3'b000); send_d(3'b000); send_d(3'b000); send_d(3'b101);
    @(negedge clock);
    check("cap_drain_cnt0", dut.cnt0, 0);
    check("cap_drain_cnt1", dut.cnt1, 0);
    cyc();

    // D routing with backpressure
    drive_a(1, 1'b1, 2'b01, 3'd4, 32'h0000_0200, 32'h0);
    expect_beat(1, 2'b01, 3'd4, 32'h0000_0200, 32'h0);
    @(negedge clock);
    cyc();
    in1_a_valid = 1'b0;
    out_d_valid = 1'b1; out_d_source = 3'b101; out_d_data = 32'hcafe_f00d;
    in1_d_ready = 1'b0; in0_d_ready = 1'b1;
    @(negedge clock);
    check("d_in1_valid", in1_d_valid, 1);
    check("d_in1_source", in1_d_source, 2'b01);
    check("d_in0_valid", in0_d_valid, 0);
    check("d_out_ready", out_d_ready, 0);
    check("d_in1_data", in1_d_data, 32'hcafe_f00d);
    cyc();
    check("d_cnt1_held", dut.cnt1, 1);
    in1_d_ready = 1'b1;
    @(negedge clock);
    check("d_out_ready_up", out_d_ready, 1);
    cyc();
    out_d_valid = 1'b0;
    @(negedge clock);
    check("d_cnt1_dec", dut.cnt1, 0);
    check("d_err_clear", err_unexpected_d, 0);
    cyc();

    // unexpected D
    send_d(3'b110);
    @(negedge clock);
    check("err_set", err_unexpected_d, 1);
    check("err_cnt1_floor", dut.cnt1, 0);
    cyc(); cyc(); cyc();
    @(negedge clock);
    check("err_sticky", err_unexpected_d, 1);
    cyc();

    // simultaneous A and D on in0, then reset
    drive_a(0, 1'b1, 2'b00, 3'd4, 32'h0000_0300, 32'h0);
    expect_beat(0, 2'b00, 3'd4, 32'h0000_0300, 32'h0);
    expect_beat(0, 2'b00, 3'd4, 32'h0000_0300, 32'h0);
    cyc(); cyc();
    expect_beat(0, 2'b00, 3'd4, 32'h0000_0300, 32'h0);
    out_d_valid = 1'b1; out_d_source = 3'b000; in0_d_ready = 1'b1;
    @(negedge clock);
    check("sim_a_ready", in0_a_ready, 1);
    check("sim_d_ready", out_d_ready, 1);
    cyc();
    in0_a_valid = 1'b0; out_d_valid = 1'b0;
    @(negedge clock);
    check("sim_cnt0", dut.cnt0, 2);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clock);
    check("rst2_cnt0", dut.cnt0, 0);
    check("rst2_prio", dut.prio, 0);
    check("rst2_err", err_unexpected_d, 0);
    check("rst2_lock", dut.lock_valid, 0);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_ul_rr_arbiter.md
# tl_ul_rr_arbiter

Two-requester TileLink-UL arbiter that shares one 32-bit TL-UL client port between two masters, such as the core data port and the debug module, in front of a single slave. It round-robins A-channel requests and tags each request with its requester index in the source MSB. It routes D-channel responses back by that tag and caps outstanding transactions per requester. A protocol monitor sits on the shared out port.

## Interface
Parameters:
- SRC_W, 2, width of each requester's a_source/d_source; out port source width is SRC_W+1.
- MAX_OUT, 4, max outstanding A-without-D per requester (1..15).

Ports (N ∈ {0,1}; inN_* is duplicated per requester):
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- inN_a_valid / inN_a_ready  input / output  1  requester A handshake.
- inN_a_opcode, inN_a_param  input  3 each  TL A opcode/param.
- inN_a_size  input  4  log2 bytes; single-beat only (≤2).
- inN_a_source  input  SRC_W  requester transaction ID.
- inN_a_address  input  32  byte address.
- inN_a_mask, inN_a_data  input  4 / 32  byte mask, write data.
- inN_d_valid / inN_d_ready  output / input  1  requester D handshake.
- inN_d_opcode, inN_d_size, inN_d_source, inN_d_denied, inN_d_data  output  3/4/SRC_W/1/32  response fields; source has the tag stripped.
- out_a_valid / out_a_ready  output / input  1  shared A handshake.
- out_a_opcode, _param, _size, _address, _mask, _data  output  as requester  muxed A fields.
- out_a_source  output  SRC_W+1  {grant index, inN_a_source}.
- out_d_valid / out_d_ready  input / output  1  shared D handshake.
- out_d_opcode, _size, _source, _denied, _data  input  3/4/SRC_W+1/1/32  slave response.
- err_unexpected_d  output  1  sticky: D arrived for a requester with zero outstanding.

## Operation
- State: prio (1 bit, requester with priority), lock_valid/lock_idx (grant held while the out A is stalled), cnt0/cnt1 (outstanding, width clog2(MAX_OUT+1)), err flag.
- Eligible_N = inN_a_valid & (cntN < MAX_OUT).
- Grant selection: if lock_valid, grant = lock_idx. Otherwise grant is the eligible requester; if both are eligible, grant = prio. If neither is eligible, out_a_valid = 0.
- out_a_valid = eligible_grant; out_a_* = inN_a_* of grant; out_a_source = {grant, inN_a_source}.
- inN_a_ready = out_a_ready & (grant == N) & eligible_N; the non-granted requester's ready = 0.
- A fire (out_a_valid & out_a_ready):
  - cnt[grant] increments.
  - prio ← ~grant.
  - lock_valid ← 0.
- out_a_valid & ~out_a_ready: lock_valid ← 1 and lock_idx ← grant. The stalled grant must not switch, which keeps TL valid/payload stable.
- D routing (combinational):
  - t = out_d_source[SRC_W].
  - inN_d_valid = out_d_valid & (t == N).
  - out_d_ready = in[t]_d_ready.
  - Fields pass through; d_source drops the MSB.
- D fire for t: cnt[t] decrements. If cnt[t] == 0 at that moment, the count is held at 0 and err ← 1 (sticky until reset).
- Simultaneous A fire and D fire on the same requester: the count is unchanged.
- a_size > 2 is not checked here; the monitor flags it.

## Timing
- A path and D path: zero cycles of latency, purely combinational muxing; state changes take effect the next cycle.
- Reset values:
  - prio = 0, lock_valid = 0, cnt0 = cnt1 = 0, err_unexpected_d = 0.
  - Outputs follow from these, so out_a_valid = 0 unless in0/in1_a_valid.
- While reset = 1:
  - All inN_a_ready = 0 and out_a_valid = 0.
  - out_d_ready = 0 and inN_d_valid = 0.
- Reset mid-transaction discards counts and the lock; no D is expected afterwards.
- Cap boundary: cntN == MAX_OUT blocks requester N. A same-cycle D fire for N does not unblock it until the next cycle; eligibility uses the registered count.
- Wrap-around: the counter can never exceed MAX_OUT and never goes below 0.

## Test plan
- Both requesters valid every cycle, out_a_ready = 1, no D → grants alternate 0,1,0,1. Out sources equal {0,s0},{1,s1}; after 4 cycles cnt0 = cnt1 = 2.
- in0 valid, out_a_ready = 0 for 3 cycles, then in1 also raises valid → out_a stays on in0 with a stable payload. After ready = 1 the in0 beat fires, then in1 is granted the next cycle.
- in0 issues 4 Gets (MAX_OUT = 4) without D → in0_a_ready = 0 on the 5th while in1 still gets through. A D with source {0,x} re-enables in0 the following cycle.
- out_d_valid with source 3'b101, in1_d_ready = 0 → in1_d_valid = 1, in1_d_source = 2'b01, in0_d_valid = 0, out_d_ready = 0. Raising in1_d_ready gives a fire and cnt1 decrements.
- D with source {1,x} while cnt1 = 0 → err_unexpected_d = 1 next cycle, cnt1 stays 0, and err stays 1 until reset.
- Same-cycle A fire and D fire for in0 with cnt0 = 2 → cnt0 = 2. Asserting reset afterwards → counts 0, prio 0, err 0 on the next edge.
